// File: rtl/btn_seq_pkg.sv
// Shared types and constants for the push-button step sequencer.
package btn_seq_pkg;

    localparam int unsigned NUM_BTN = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATHER = 2'd1,
        EMIT   = 2'd2
    } state_e;

    localparam logic [1:0] CODE_B0    = 2'b01;
    localparam logic [1:0] CODE_B1    = 2'b10;
    localparam logic [1:0] CODE_CHORD = 2'b11;

    typedef struct packed {
        logic [1:0] code;
        logic       is_long;
    } step_t;

endpackage

// File: rtl/btn_debounce.sv
// One push button: 2-FF synchroniser, stability counter, debounced level and press pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic level,
    output logic press
);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             pressed;

    assign pressed = ~sync2;

    // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (pressed == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level <= pressed;
                press <= pressed;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/btn_step_sequencer.sv
// Turns two debounced buttons into one step event per gesture, offered over valid/ready.
module btn_step_sequencer
    import btn_seq_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned HOLD_CYCLES     = 25000000,
    parameter int unsigned CNT_W           = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] btn_n,
    input  logic       step_ready,
    output logic       step_valid,
    output logic [1:0] step_code,
    output logic       step_long,
    output logic       overrun,
    output logic [1:0] btn_level
);

    logic [NUM_BTN-1:0] press;

    for (genvar i = 0; i < int'(NUM_BTN); i++) begin : g_db
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk  (clk),
            .reset(reset),
            .btn_n(btn_n[i]),
            .level(btn_level[i]),
            .press(press[i])
        );
    end

    state_e             state_q, state_d;
    logic [NUM_BTN-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic               valid_q, valid_d;
    step_t              step_q, step_d;
    logic               overrun_q, overrun_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            hold_q    <= '0;
            valid_q   <= 1'b0;
            step_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            hold_q    <= hold_d;
            valid_q   <= valid_d;
            step_q    <= step_d;
            overrun_q <= overrun_d;
        end
    end

    // Gesture runs from the first press until both debounced levels are low again.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        hold_d    = hold_q;
        valid_d   = valid_q;
        step_d    = step_q;
        overrun_d = overrun_q;
        case (state_q)
            IDLE: begin
                if (|press) begin
                    state_d = GATHER;
                    acc_d   = press;
                    hold_d  = '0;
                end
            end
            GATHER: begin
                acc_d = acc_q | btn_level;
                if (hold_q != CNT_W'(HOLD_CYCLES)) begin
                    hold_d = hold_q + CNT_W'(1);
                end
                if (btn_level == 2'b00) begin
                    step_d.code    = acc_q;
                    step_d.is_long = (hold_q == CNT_W'(HOLD_CYCLES));
                    valid_d        = 1'b1;
                    state_d        = EMIT;
                end
            end
            EMIT: begin
                if (|press) begin
                    overrun_d = 1'b1;
                end
                if (valid_q && step_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign step_valid = valid_q;
    assign step_code  = step_q.code;
    assign step_long  = step_q.is_long;
    assign overrun    = overrun_q;

endmodule
